bcd_display_scan: RTL
=====================

Name: bcd_display_scan

Overview:
- Downstream consumer of the BCD hours/minutes clock outputs. Drives a 4-digit, common-anode, multiplexed seven-segment display.
- Time-multiplexes the four BCD digits, decodes each digit to segments, and blinks the colon (decimal point on digit 2) from a seconds tick.
- Shadow-latches the digits once per scan frame so a mid-frame time update never tears the display.

Parameters:
- REFRESH_DIV, 50000: clk cycles each digit stays lit; legal range 1..2^20.
- CNT_W, 20: refresh counter width; must hold REFRESH_DIV-1.

Ports:
- clk  input  1  single system clock; everything is on its rising edge.
- reset  input  1  synchronous, active-high reset.
- ms_hour  input  4  BCD tens of hours.
- ls_hour  input  4  BCD units of hours.
- ms_min  input  4  BCD tens of minutes.
- ls_min  input  4  BCD units of minutes.
- sec_tick  input  1  one-cycle pulse, once per second; toggles colon state.
- blank  input  1  level; 1 forces display dark.
- an  output  4  digit anodes, active low; an[0] is the rightmost digit (ls_min), an[3] is ms_hour.
- seg  output  7  segments {g,f,e,d,c,b,a}, active low.
- dp  output  1  decimal point, active low; used as colon.

Behaviour:
- One clock, clk. Reset is synchronous and active-high, named reset. Reset dominates every other input in the same cycle.
- Reset values:
  - an=4'b1111, seg=7'b1111111, dp=1.
  - refresh count=0, digit index=0, colon state=0.
  - All four shadow digits=0.
- Refresh counter:
  - Counts 0..REFRESH_DIV-1, then wraps to 0.
  - The wrap cycle is the advance event. Digit index then steps 0->1->2->3->0.
  - REFRESH_DIV=1: advance every cycle.
- Shadow load:
  - On the advance from index 3 to 0, all four inputs are captured together into the shadow registers.
  - Also captured on the first cycle after reset deasserts, so the display is valid immediately.
  - Inputs are never sampled at any other time. A change mid-frame is shown from the next frame on.
- Outputs are registered with 1 cycle latency: the outputs reflect the index and shadow value of the previous cycle.
- Anode drive:
  - an has exactly one bit low, selected by index. All bits are high when blank=1.
  - Index mapping: 0=ls_min, 1=ms_min, 2=ls_hour, 3=ms_hour.
- Decode (active low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001.
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Any value 10..15 shows a dash, 0111111.
- Colon:
  - sec_tick=1 toggles colon state.
  - dp=0 only while index=2, colon state=1 and blank=0; otherwise dp=1.
- blank=1: an=1111, seg=1111111, dp=1. Counters, index, colon state and shadow loads keep running, so scan phase is unaffected.
- Reset mid-frame: the next cycle restarts at index 0 with count 0. Shadows reload on the first cycle after reset deasserts.

Optional Feature:
- Macro: BCD_DISPLAY_LEADING_ZERO_BLANK_EN.
- Defined: when shadow ms_hour==0 and index=3, an stays 1111 for that slot and seg=1111111. All other digits are unaffected.
- Undefined: ms_hour==0 displays "0" (seg=1000000). No other difference.

Test Plan:
- Reset and first frame. Stimulus: REFRESH_DIV=4; reset for 3 cycles; inputs 1,2,3,4 (ms_hour..ls_min); release. Required: the cycle after release shows an=1111/seg=1111111; the next cycle shows an=1110 with seg=0011001 ("4"). an steps 1101, 1011, 0111 every 4 cycles, showing "3", "2", "1".
- Frame-boundary latch. Stimulus: change ls_min from 4 to 9 while index=1. Required: digit 0 keeps showing "4" until the 3->0 advance, then shows 0010000.
- Invalid BCD. Stimulus: ms_min=4'hC. Required: when an=1101, seg=0111111.
- Colon blink. Stimulus: pulse sec_tick once. Required: dp=0 only during an=1011 slots. A second pulse returns dp to a constant 1.
- blank and reset dominance. Stimulus: assert blank for 5 cycles mid-frame. Required: all outputs dark, and scan index continues on the original schedule after blank drops. Then assert reset together with sec_tick; required: colon state=0.
- Leading zero (macro defined). Stimulus: ms_hour=0, ls_hour=7. Required: an never equals 0111. With the macro undefined, an=0111 with seg=1000000.

Source files
------------

// File: rtl/bcd_display_scan.sv
// Four-digit multiplexed seven-segment driver for the BCD hours/minutes clock.
// Optional: define BCD_DISPLAY_LEADING_ZERO_BLANK_EN to hide a zero tens-of-hours digit.
module bcd_display_scan #(
    parameter int unsigned REFRESH_DIV = 50000,
    parameter int unsigned CNT_W       = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] ms_hour,
    input  logic [3:0] ls_hour,
    input  logic [3:0] ms_min,
    input  logic [3:0] ls_min,
    input  logic       sec_tick,
    input  logic       blank,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    logic [CNT_W-1:0] cnt;
    logic [1:0]       idx;
    logic             colon;
    logic             load_pending;
    logic [3:0]       sh_ms_hour, sh_ls_hour, sh_ms_min, sh_ls_min;

    logic             advance;
    logic             frame_end;
    logic [3:0]       digit;
    logic             dark;
    logic [3:0]       an_next;
    logic [6:0]       seg_next;
    logic             dp_next;

    assign advance   = (cnt == CNT_W'(REFRESH_DIV - 1));
    assign frame_end = advance && (idx == 2'd3);

    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b0111111;
        endcase
        return s;
    endfunction

    // load_pending marks the first post-reset cycle: shadows are captured then
    // and the output register stays dark because the shadows are not yet valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt          <= '0;
            idx          <= 2'd0;
            colon        <= 1'b0;
            load_pending <= 1'b1;
            sh_ms_hour   <= '0;
            sh_ls_hour   <= '0;
            sh_ms_min    <= '0;
            sh_ls_min    <= '0;
        end else begin
            cnt          <= advance ? '0 : cnt + CNT_W'(1);
            load_pending <= 1'b0;
            if (advance) begin
                idx <= idx + 2'd1;
            end
            if (sec_tick) begin
                colon <= ~colon;
            end
            if (load_pending || frame_end) begin
                sh_ms_hour <= ms_hour;
                sh_ls_hour <= ls_hour;
                sh_ms_min  <= ms_min;
                sh_ls_min  <= ls_min;
            end
        end
    end

    always_comb begin
        digit    = sh_ls_min;
        dark     = blank || load_pending;
        an_next  = '1;
        seg_next = '1;
        dp_next  = 1'b1;
        case (idx)
            2'd0:    digit = sh_ls_min;
            2'd1:    digit = sh_ms_min;
            2'd2:    digit = sh_ls_hour;
            default: digit = sh_ms_hour;
        endcase
`ifdef BCD_DISPLAY_LEADING_ZERO_BLANK_EN
        if ((idx == 2'd3) && (sh_ms_hour == 4'd0)) begin
            dark = 1'b1;
        end
`endif
        if (!dark) begin
            an_next  = ~(4'b0001 << idx);
            seg_next = decode(digit);
        end
        if (!blank && !load_pending && colon && (idx == 2'd2)) begin
            dp_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            an  <= '1;
            seg <= '1;
            dp  <= 1'b1;
        end else begin
            an  <= an_next;
            seg <= seg_next;
            dp  <= dp_next;
        end
    end

endmodule
